// File: rtl/parity_accumulator.sv
// Frame-wise XOR/XNOR parity accumulator with valid/ready handshakes on both sides.
// A frame closes on in_last or after FRAME_LEN words; the result is held until acknowledged.
module parity_accumulator #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [7:0]       out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] FRAME_LEN_W = 8'(FRAME_LEN);

    state_t     state_q, state_d;
    logic       acc_q, acc_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;

    logic       in_ready_d;
    logic       out_valid_d;
    logic       out_parity_d;
    logic [7:0] out_count_d;

    logic       transfer;
    logic       word_par;

    assign transfer = in_valid & in_ready;
    assign word_par = ^in_data;

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= 1'b0;
            cnt_q      <= 8'd0;
            mode_q     <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_parity <= 1'b0;
            out_count  <= 8'd0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            in_ready   <= in_ready_d;
            out_valid  <= out_valid_d;
            out_parity <= out_parity_d;
            out_count  <= out_count_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    acc_d   = word_par;
                    cnt_d   = 8'd1;
                    mode_d  = mode;
                    state_d = (in_last || (FRAME_LEN_W == 8'd1)) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (transfer) begin
                    acc_d   = acc_q ^ word_par;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = (in_last || (cnt_d == FRAME_LEN_W)) ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        in_ready_d   = 1'b1;
        out_valid_d  = 1'b0;
        out_parity_d = 1'b0;
        out_count_d  = 8'd0;
        if (state_d == HOLD) begin
            in_ready_d   = 1'b0;
            out_valid_d  = 1'b1;
            out_parity_d = acc_d ^ mode_d;
            out_count_d  = cnt_d;
        end
    end

endmodule

// File: tb/tb_parity_accumulator.sv
// Self-checking bench: directed and randomized frames against a popcount reference model,
// on a FRAME_LEN=4 instance and a FRAME_LEN=1 instance.
module tb_parity_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0, in_last = 1'b0, mode = 1'b0, out_ready = 1'b0;
    logic [2:0] in_data = 3'd0;
    logic       in_ready, out_valid, out_parity;
    logic [7:0] out_count;

    logic       in_valid1 = 1'b0, in_last1 = 1'b0, mode1 = 1'b0, out_ready1 = 1'b0;
    logic [2:0] in_data1 = 3'd0;
    logic       in_ready1, out_valid1, out_parity1;
    logic [7:0] out_count1;

    int total = 0;
    int bad   = 0;

    parity_accumulator #(.WIDTH(3), .FRAME_LEN(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_parity(out_parity), .out_count(out_count)
    );

    parity_accumulator #(.WIDTH(3), .FRAME_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .in_last(in_last1), .mode(mode1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_parity(out_parity1), .out_count(out_count1)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: parity of all ones in the frame, inverted when the first word asked for XNOR
    function automatic logic ref_par(input logic [2:0] w[$], input logic m);
        int ones = 0;
        foreach (w[i]) ones += $countones(w[i]);
        return (ones % 2 == 1) ^ m;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send4(input logic [2:0] d, input logic m, input logic l);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = d; mode = m; in_last = l;
        tick();
        in_valid = 1'b0; in_last = 1'b0; in_data = 3'($urandom); mode = 1'($urandom);
    endtask

    task automatic expect4(input logic exp_p, input int exp_c, input int hold);
        for (int i = 0; i <= hold; i++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_parity", 32'(out_parity), 32'(exp_p));
            check("hold_count", 32'(out_count), 32'(exp_c));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            if (i < hold) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ack_valid_drop", 32'(out_valid), 32'd0);
        check("ack_parity_zero", 32'(out_parity), 32'd0);
        check("ack_count_zero", 32'(out_count), 32'd0);
        check("ack_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic frame4(input logic [2:0] w[$], input logic m_first, input logic m_rest,
                          input logic last_final, input int hold, input int max_gap);
        for (int i = 0; i < w.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                tick();
                check("stall_no_valid", 32'(out_valid), 32'd0);
            end
            send4(w[i], (i == 0) ? m_first : m_rest, (i == w.size() - 1) ? last_final : 1'b0);
            if (i < w.size() - 1) check("no_early_valid", 32'(out_valid), 32'd0);
        end
        expect4(ref_par(w, m_first), w.size(), hold);
    endtask

    initial begin
        logic [2:0] q[$];
        logic [2:0] d1[5];
        logic       e1[5];
        logic       m;
        int         n;

        repeat (2) tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_parity", 32'(out_parity), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_in_ready1", 32'(in_ready1), 32'd1);

        // Full frame XOR, closed by count
        q = '{3'b001, 3'b011, 3'b111, 3'b000};
        frame4(q, 1'b0, 1'b0, 1'b0, 0, 0);
        // Early termination with XNOR
        q = '{3'b101, 3'b100};
        frame4(q, 1'b1, 1'b1, 1'b1, 0, 0);
        // Backpressure for 5 cycles
        q = '{3'b010, 3'b011, 3'b110};
        frame4(q, 1'b0, 1'b0, 1'b1, 5, 0);
        // Mode captured from first word only
        q = '{3'b001, 3'b010, 3'b000};
        frame4(q, 1'b1, 1'b0, 1'b1, 0, 0);
        // in_last coinciding with count limit: single report only
        q = '{3'b001, 3'b001, 3'b001, 3'b001};
        frame4(q, 1'b0, 1'b0, 1'b1, 0, 0);
        repeat (3) begin
            tick();
            check("no_double_report", 32'(out_valid), 32'd0);
        end

        // Stall in ACCUM
        send4(3'b011, 1'b0, 1'b0);
        repeat (4) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd0);
            check("stall_in_ready", 32'(in_ready), 32'd1);
        end
        send4(3'b100, 1'b0, 1'b1);
        expect4(1'b1, 2, 0);

        // Reset mid-frame discards the partial frame
        send4(3'b111, 1'b0, 1'b0);
        send4(3'b110, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        send4(3'b001, 1'b0, 1'b1);
        expect4(1'b1, 1, 0);

        // Reset in HOLD drops the pending result
        send4(3'b111, 1'b1, 1'b1);
        check("pre_rst_hold_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("holdrst_valid", 32'(out_valid), 32'd0);
        check("holdrst_count", 32'(out_count), 32'd0);
        check("holdrst_in_ready", 32'(in_ready), 32'd1);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, 4);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(3'($urandom));
            m = 1'($urandom);
            frame4(q, m, 1'($urandom), (n < 4) ? 1'b1 : 1'($urandom), $urandom_range(0, 3), 2);
        end

        // FRAME_LEN=1: registered XNOR gate
        d1 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
        e1 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            in_valid1 = 1'b1; in_data1 = d1[i]; mode1 = 1'b1;
            tick();
            in_valid1 = 1'b0;
            check("fl1_valid", 32'(out_valid1), 32'd1);
            check("fl1_parity", 32'(out_parity1), 32'(e1[i]));
            check("fl1_count", 32'(out_count1), 32'd1);
            check("fl1_in_ready", 32'(in_ready1), 32'd0);
            out_ready1 = 1'b1;
            tick();
            out_ready1 = 1'b0;
            check("fl1_ack_valid", 32'(out_valid1), 32'd0);
            check("fl1_ack_in_ready", 32'(in_ready1), 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            q = {};
            q.push_back(3'($urandom));
            m = 1'($urandom);
            in_valid1 = 1'b1; in_data1 = q[0]; mode1 = m;
            tick();
            in_valid1 = 1'b0;
            check("fl1_rand_parity", 32'(out_parity1), 32'(ref_par(q, m)));
            check("fl1_rand_count", 32'(out_count1), 32'd1);
            out_ready1 = 1'b1;
            tick();
            out_ready1 = 1'b0;
            check("fl1_rand_drop", 32'(out_valid1), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
